// File: rtl/bus_decode_ws.sv
// Purpose : 8088 minimum-mode bus front end: address latch, N-region chip-select decode,
//           per-region wait-state generator driving READY, bus-error pulse, transceiver steering.
// Latency : Address/CS one cycle after the ALE edge; READY low for exactly WS cycles from the
//           strobe-sampling edge; BUSERR one cycle; XA2B/XB2A combinational.
// Flow    : none; the processor is throttled only through READY.
//
// Ports:
//   CLK, RESET        bus clock, synchronous active-high reset
//   ALE, IOM          address latch enable, 1 = I/O cycle
//   RD, WR, DEN       active-low read/write strobes and data enable
//   DTR               data transmit (1) / receive (0)
//   A, AD             upper address and multiplexed low address
//   Address, CS       latched address and one-hot (or zero) chip selects
//   READY, BUSERR     processor ready, undecoded/illegal strobe pulse
//   XA2B, XB2A        transceiver direction enables
module bus_decode_ws #(
  parameter int ADDR_BITS   = 20,
  parameter int LOW_BITS    = 8,
  parameter int NUM_REGIONS = 4,
  parameter int WS_BITS     = 3,
  parameter logic [NUM_REGIONS*ADDR_BITS-1:0] REGION_BASE =
    {20'h01C00, 20'h0FF00, 20'h00000, 20'h80000},
  parameter logic [NUM_REGIONS*ADDR_BITS-1:0] REGION_MASK =
    {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NUM_REGIONS-1:0] REGION_IO = 4'b1100,
  parameter logic [NUM_REGIONS*WS_BITS-1:0] REGION_WS =
    {3'd2, 3'd1, 3'd0, 3'd0}
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ALE,
  input  logic                          IOM,
  input  logic                          RD,
  input  logic                          WR,
  input  logic                          DTR,
  input  logic                          DEN,
  input  logic [ADDR_BITS-LOW_BITS-1:0] A,
  input  logic [LOW_BITS-1:0]           AD,
  output logic [ADDR_BITS-1:0]          Address,
  output logic [NUM_REGIONS-1:0]        CS,
  output logic                          READY,
  output logic                          BUSERR,
  output logic                          XA2B,
  output logic                          XB2A
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_DONE} state_t;

  state_t                   r_state;
  logic [WS_BITS-1:0]       r_cnt;
  logic [ADDR_BITS-1:0]     r_addr;
  logic [NUM_REGIONS-1:0]   r_cs;
  logic                     r_ready;
  logic                     r_buserr;

  logic [ADDR_BITS-1:0]     w_addr;
  logic [NUM_REGIONS-1:0]   w_cs_next;
  logic [WS_BITS-1:0]       w_ws;
  logic                     w_strb;
  logic                     w_both;

  assign w_addr = {A, AD};
  assign w_strb = ~RD | ~WR;
  assign w_both = ~RD & ~WR;

  // Priority decode: walk from the top so the lowest matching region is written last and wins.
  // The I/O-vs-memory qualifier is folded in here, so CS alone carries the cycle's space.
  always_comb begin
    w_cs_next = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((((w_addr ^ REGION_BASE[i*ADDR_BITS +: ADDR_BITS]) &
            REGION_MASK[i*ADDR_BITS +: ADDR_BITS]) == '0) && (IOM == REGION_IO[i])) begin
        w_cs_next    = '0;
        w_cs_next[i] = 1'b1;
      end
    end
  end

  // CS is one-hot or zero, so OR-ing the masked fields selects the active region's wait count.
  always_comb begin
    w_ws = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (r_cs[i]) begin
        w_ws = w_ws | REGION_WS[i*WS_BITS +: WS_BITS];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr   <= '0;
      r_cs     <= '0;
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_buserr <= 1'b0;
    end else begin
      // The latch runs independently of the FSM; a new ALE mid-cycle does not disturb the count.
      if (ALE) begin
        r_addr <= w_addr;
        r_cs   <= w_cs_next;
      end

      r_buserr <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_both || (w_strb && (r_cs == '0))) begin
            r_buserr <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_strb) begin
            if (w_ws == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_ready <= 1'b0;
              r_cnt   <= w_ws;
              r_state <= ST_COUNT;
            end
          end
        end

        ST_COUNT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == WS_BITS'(1)) begin
            r_ready <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Wait for both strobes high so one long strobe is serviced only once.
          if (RD && WR) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign Address = r_addr;
  assign CS      = r_cs;
  assign READY   = r_ready;
  assign BUSERR  = r_buserr;
  assign XA2B    = DTR & ~DEN;
  assign XB2A    = ~DTR & ~DEN;

endmodule

// File: tb/tb_bus_decode_ws.sv
module tb_bus_decode_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        ale, iom, rd, wr, dtr, den;
  logic [11:0] a;
  logic [7:0]  ad;

  logic [19:0] addr0, addr1;
  logic [3:0]  cs0;
  logic [1:0]  cs1;
  logic        ready0, ready1, buserr0, buserr1;
  logic        xa2b0, xb2a0, xa2b1, xb2a1;

  int total = 0;
  int bad   = 0;
  int lows, errs;

  always #5 clk = ~clk;

  bus_decode_ws dut (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
    .DTR(dtr), .DEN(den), .A(a), .AD(ad),
    .Address(addr0), .CS(cs0), .READY(ready0), .BUSERR(buserr0),
    .XA2B(xa2b0), .XB2A(xb2a0)
  );

  // Two regions: region 0 = low memory (3 WS), region 1 = high memory (7 WS).
  bus_decode_ws #(
    .NUM_REGIONS(2),
    .REGION_BASE({20'h80000, 20'h00000}),
    .REGION_MASK({20'h80000, 20'h80000}),
    .REGION_IO  (2'b00),
    .REGION_WS  ({3'd7, 3'd3})
  ) dut2 (
    .CLK(clk), .RESET(rst), .ALE(ale), .IOM(iom), .RD(rd), .WR(wr),
    .DTR(dtr), .DEN(den), .A(a), .AD(ad),
    .Address(addr1), .CS(cs1), .READY(ready1), .BUSERR(buserr1),
    .XA2B(xa2b1), .XB2A(xb2a1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Count cycles with READY low and BUSERR high over a fixed window of edges.
  task automatic window(input int which, input int n, output int low_cnt, output int err_cnt);
    low_cnt = 0;
    err_cnt = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (which == 0) begin
        if (ready0 == 1'b0) low_cnt++;
        if (buserr0 == 1'b1) err_cnt++;
      end else begin
        if (ready1 == 1'b0) low_cnt++;
        if (buserr1 == 1'b1) err_cnt++;
      end
    end
  endtask

  task automatic latch(input logic io, input logic [19:0] ad20);
    iom = io;
    a   = ad20[19:8];
    ad  = ad20[7:0];
    ale = 1'b1;
    tick();
    ale = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ale = 1'b0; iom = 1'b0; rd = 1'b1; wr = 1'b1;
    dtr = 1'b0; den = 1'b1; a = 12'h000; ad = 8'h00;

    // Reset
    tick(); tick();
    chk("rst_addr",   32'(addr0),   32'h0);
    chk("rst_cs",     32'(cs0),     32'h0);
    chk("rst_ready",  32'(ready0),  32'h1);
    chk("rst_buserr", 32'(buserr0), 32'h0);
    chk("rst_ready2", 32'(ready1),  32'h1);
    rst = 1'b0;
    tick();

    // Memory decode, zero wait states
    latch(1'b0, 20'h80012);
    chk("mem_addr0", 32'(addr0), 32'h80012);
    chk("mem_cs0",   32'(cs0),   32'h1);
    latch(1'b0, 20'h00034);
    chk("mem_addr1", 32'(addr0), 32'h00034);
    chk("mem_cs1",   32'(cs0),   32'h2);
    rd = 1'b0;
    window(0, 8, lows, errs);
    chk("mem_rd_lows", 32'(lows), 32'd0);
    chk("mem_rd_errs", 32'(errs), 32'd0);
    rd = 1'b1; tick(); tick();

    // I/O region 2: 1 wait state
    latch(1'b1, 20'h0FF05);
    chk("io1_cs", 32'(cs0), 32'h4);
    rd = 1'b0;
    window(0, 6, lows, errs);
    chk("io1_lows", 32'(lows), 32'd1);
    chk("io1_errs", 32'(errs), 32'd0);
    rd = 1'b1; tick(); tick();

    // I/O region 3: 2 wait states, strobe held long afterwards
    latch(1'b1, 20'h01C80);
    chk("io2_cs", 32'(cs0), 32'h8);
    wr = 1'b0;
    tick();
    chk("io2_first_ready", 32'(ready0), 32'h0);
    window(0, 9, lows, errs);
    chk("io2_lows_rest", 32'(lows), 32'd1);
    chk("io2_errs", 32'(errs), 32'd0);
    wr = 1'b1; tick(); tick();

    // Wrong space: memory region address in an I/O cycle
    latch(1'b1, 20'h80000);
    chk("err_cs", 32'(cs0), 32'h0);
    rd = 1'b0;
    tick();
    chk("err_pulse", 32'(buserr0), 32'h1);
    chk("err_ready", 32'(ready0),  32'h1);
    window(0, 5, lows, errs);
    chk("err_lows", 32'(lows), 32'd0);
    chk("err_once", 32'(errs), 32'd0);
    rd = 1'b1; tick(); tick();

    // Both strobes low in a valid 2-WS region
    latch(1'b1, 20'h01C80);
    chk("both_cs", 32'(cs0), 32'h8);
    rd = 1'b0; wr = 1'b0;
    window(0, 6, lows, errs);
    chk("both_lows", 32'(lows), 32'd0);
    chk("both_errs", 32'(errs), 32'd1);
    rd = 1'b1; wr = 1'b1; tick(); tick();

    // Reset in the middle of a 2-WS count
    wr = 1'b0;
    tick();
    chk("midrst_low", 32'(ready0), 32'h0);
    rst = 1'b1;
    tick();
    chk("midrst_ready", 32'(ready0), 32'h1);
    chk("midrst_cs",    32'(cs0),    32'h0);
    chk("midrst_addr",  32'(addr0),  32'h0);
    rst = 1'b0; wr = 1'b1;
    tick(); tick();

    // Transceiver steering
    dtr = 1'b0; den = 1'b0; #1;
    chk("xcv00", 32'({xa2b0, xb2a0}), 32'b01);
    dtr = 1'b0; den = 1'b1; #1;
    chk("xcv01", 32'({xa2b0, xb2a0}), 32'b00);
    dtr = 1'b1; den = 1'b0; #1;
    chk("xcv10", 32'({xa2b0, xb2a0}), 32'b10);
    chk("xcv10_inst2", 32'({xa2b1, xb2a1}), 32'b10);
    dtr = 1'b1; den = 1'b1; #1;
    chk("xcv11", 32'({xa2b0, xb2a0}), 32'b00);

    // Overridden parameters: region 1 = 7 WS, region 0 = 3 WS
    latch(1'b0, 20'h80000);
    chk("ovr_addr", 32'(addr1), 32'h80000);
    chk("ovr_cs1",  32'(cs1),   32'h2);
    rd = 1'b0;
    window(1, 12, lows, errs);
    chk("ovr_r1_lows", 32'(lows), 32'd7);
    chk("ovr_r1_errs", 32'(errs), 32'd0);
    rd = 1'b1; tick(); tick();
    latch(1'b0, 20'h00000);
    chk("ovr_cs0", 32'(cs1), 32'h1);
    wr = 1'b0;
    window(1, 8, lows, errs);
    chk("ovr_r0_lows", 32'(lows), 32'd3);
    wr = 1'b1; tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
